// File: rtl/fsm_pkg.sv
// Shared definitions for both ends of the two-beat float link.
// Covers FSM state encoding, classification codes and IEEE-754 field widths.
package fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_SEND_HI  = 2'b01,
    ST_SEND_LO  = 2'b10,
    ST_GAP_WAIT = 2'b11
  } fsm_state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_NAN = 2'b01;
  localparam logic [1:0] ERR_INF = 2'b10;
  localparam logic [1:0] ERR_DEN = 2'b11;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

endpackage

// File: rtl/fsm_tx_if.sv
// Upstream word/request plus downstream beat handshake of the transmitter.
// The master side drives requests and ready; the slave side is the transmitter.
interface fsm_tx_if #(
  parameter int WORD_W = 16
);

  logic                  R_I;
  logic [2*WORD_W-1:0]   dataIn;
  logic                  a_i;
  logic [WORD_W-1:0]     dataOut;
  logic                  r_o;
  logic [1:0]            err;
  logic                  busy;

  modport master (
    output R_I, dataIn, a_i,
    input  dataOut, r_o, err, busy
  );

  modport slave (
    input  R_I, dataIn, a_i,
    output dataOut, r_o, err, busy
  );

endinterface

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier.
// Shared by transmitter and receiver so both ends agree on the class codes.
module fp_classify
  import fsm_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [1:0]  o_err
);

  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;

  assign w_exp = i_word[30:23];
  assign w_man = i_word[22:0];

  // Exponent all-ones splits NaN from Inf; exponent zero with a mantissa is denormal.
  always_comb begin
    o_err = ERR_OK;
    if (w_exp == {EXP_W{1'b1}}) begin
      if (w_man != {MAN_W{1'b0}}) begin
        o_err = ERR_NAN;
      end else begin
        o_err = ERR_INF;
      end
    end else if ((w_exp == {EXP_W{1'b0}}) && (w_man != {MAN_W{1'b0}})) begin
      o_err = ERR_DEN;
    end else begin
      o_err = ERR_OK;
    end
  end

endmodule

// File: rtl/fsm_tx.sv
// Transmit FSM: latches a 32-bit float, sends it as HI then LO beats on valid/ready,
// reports its class on err and enforces GAP idle cycles between frames.
module fsm_tx
  import fsm_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int GAP    = 1
)(
  input  logic       clk,
  input  logic       reset,
  fsm_tx_if.slave    bus
);

  localparam int CNT_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP > 0) ? (GAP - 1) : 0);

  fsm_state_t            r_state;
  logic [2*WORD_W-1:0]   r_hold;
  logic [WORD_W-1:0]     r_data_out;
  logic                  r_r_o;
  logic [1:0]            r_err;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_gap_cnt;
  logic [1:0]            w_err;

  fp_classify u_classify (
    .i_word (bus.dataIn),
    .o_err  (w_err)
  );

  // Frame sequencer with all outputs registered; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_hold     <= {(2*WORD_W){1'b0}};
      r_data_out <= {WORD_W{1'b0}};
      r_r_o      <= 1'b0;
      r_err      <= ERR_OK;
      r_busy     <= 1'b0;
      r_gap_cnt  <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.R_I) begin
            r_hold     <= bus.dataIn;
            r_err      <= w_err;
            r_data_out <= bus.dataIn[2*WORD_W-1:WORD_W];
            r_r_o      <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= ST_SEND_HI;
          end
        end
        ST_SEND_HI: begin
          if (bus.a_i) begin
            r_data_out <= r_hold[WORD_W-1:0];
            r_state    <= ST_SEND_LO;
          end else begin
            r_data_out <= r_hold[2*WORD_W-1:WORD_W];
          end
        end
        ST_SEND_LO: begin
          if (bus.a_i) begin
            r_r_o     <= 1'b0;
            r_gap_cnt <= {CNT_W{1'b0}};
            if (GAP > 0) begin
              r_state <= ST_GAP_WAIT;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_GAP_WAIT: begin
          // busy stays high here so a request cannot sneak in before the gap ends
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_r_o   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dataOut = r_data_out;
  assign bus.r_o     = r_r_o;
  assign bus.err     = r_err;
  assign bus.busy    = r_busy;

endmodule
